// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage feeding the opcode decoder. Holds the PC, issues one
// word request at a time to instruction memory (req/gnt/rvalid handshake),
// buffers returned words in a 2-entry FIFO and presents the head entry to
// decode under a valid/ready handshake. A redirect flushes the FIFO and
// cancels any in-flight fetch.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst_n        in   synchronous active-low reset
//   imem_req     out  fetch request for imem_addr
//   imem_addr    out  current PC
//   imem_gnt     in   memory accepted the request this cycle
//   imem_rvalid  in   response word valid (at most one per grant)
//   imem_rdata   in   instruction word
//   redirect     in   taken branch/jump from downstream
//   redirect_pc  in   new PC when redirect
//   id_ready     in   decode accepts the head instruction
//   id_valid     out  head instruction present
//   id_instr     out  head instruction
//   id_op        out  id_instr[31:26]
//   id_pc        out  PC of head instruction
//   id_illegal   out  id_valid and id_op is not a known opcode
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [5:0]        id_op,
    output logic [ADDR_W-1:0] id_pc,
    output logic              id_illegal
);

    // S_FETCH: nothing outstanding; S_WAIT: granted request, response pending;
    // S_DISCARD: response pending but it belongs to a cancelled fetch.
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tag;          // PC of the in-flight request
    logic [1:0]        count;        // FIFO occupancy, 0..2
    logic [31:0]       q_instr [2];  // entry 0 is always the head
    logic [ADDR_W-1:0] q_pc    [2];

    logic       pop;
    logic       push;
    logic       fire;
    logic       room;
    logic [1:0] slots;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd4,
            6'd10, 6'd11, 6'd12, 6'd13, 6'd14,
            6'd20, 6'd21, 6'd30, 6'd31: op_legal = 1'b1;
            default:                    op_legal = 1'b0;
        endcase
    endfunction

    assign imem_addr  = pc;
    assign id_valid   = (count != 2'd0);
    assign id_instr   = q_instr[0];
    assign id_pc      = q_pc[0];
    assign id_op      = id_instr[31:26];
    assign id_illegal = id_valid & ~op_legal(id_op);
    assign pop        = id_valid & id_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next = state;
        // A pending response reserves a FIFO slot, so a request is only made
        // when the word it returns is guaranteed somewhere to land.
        slots = count + {1'b0, state == S_WAIT};
        room  = (slots < 2'd2) | (pop & (slots == 2'd2));
        imem_req = rst_n & ~redirect & room &
                   ((state == S_FETCH) | ((state == S_WAIT) & imem_rvalid));
        fire = imem_req & imem_gnt;
        push = (state == S_WAIT) & imem_rvalid & ~redirect;

        case (state)
            S_FETCH: begin
                if (fire) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (redirect)         state_next = imem_rvalid ? S_FETCH : S_DISCARD;
                else if (imem_rvalid) state_next = fire ? S_WAIT : S_FETCH;
            end
            S_DISCARD: begin
                // The cancelled word is dropped on arrival even if another
                // redirect lands in the same cycle; waiting longer would
                // stall forever since no second response will come.
                if (imem_rvalid) state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            tag   <= '0;
            count <= 2'd0;
            // NOTE: the FIFO storage is reset too because its head drives the
            // id_* outputs directly and those must read zero out of reset.
            for (int i = 0; i < 2; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else begin
            state <= state_next;

            if (redirect)  pc <= redirect_pc;
            else if (fire) pc <= pc + ADDR_W'(4);

            if (fire) tag <= pc;

            if (redirect) begin
                count <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b11: begin
                        if (count == 2'd1) begin
                            q_instr[0] <= imem_rdata;
                            q_pc[0]    <= tag;
                        end else begin
                            q_instr[0] <= q_instr[1];
                            q_pc[0]    <= q_pc[1];
                            q_instr[1] <= imem_rdata;
                            q_pc[1]    <= tag;
                        end
                    end
                    2'b10: begin
                        q_instr[count[0]] <= imem_rdata;
                        q_pc[count[0]]    <= tag;
                        count             <= count + 2'd1;
                    end
                    2'b01: begin
                        q_instr[0] <= q_instr[1];
                        q_pc[0]    <= q_pc[1];
                        count      <= count - 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage feeding the opcode decoder. Holds the PC, issues one-at-a-time word requests to instruction memory over a request/grant/response handshake, buffers returned instructions in a 2-entry queue, and presents them with their PC and decoded `op` field to decode under a valid/ready handshake. Taken BEQ/JUMP redirects flush the queue and cancel any in-flight fetch.

## Interface
- `ADDR_W`, 32: PC and instruction-memory address width.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `imem_req` out 1: fetch request for `imem_addr`.
- `imem_addr` out ADDR_W: current PC.
- `imem_gnt` in 1: memory accepted the request this cycle; only meaningful with `imem_req`.
- `imem_rvalid` in 1: response word valid; at most one per grant, never in the grant cycle.
- `imem_rdata` in 32: instruction word.
- `redirect` in 1: taken branch/jump from downstream.
- `redirect_pc` in ADDR_W: new PC when `redirect`.
- `id_ready` in 1: decode accepts the head instruction.
- `id_valid` out 1: head instruction present.
- `id_instr` out 32: head instruction.
- `id_op` out 6: `id_instr[31:26]`.
- `id_pc` out ADDR_W: PC of head instruction.
- `id_illegal` out 1: `id_valid` and `id_op` not in {0–4, 10–14, 20, 21, 30, 31}.

## Operation
- State machine: FETCH (nothing outstanding), WAIT (one request granted, response pending), DISCARD (response pending but must be dropped).
- `slots` = queue count + (1 if WAIT). `pop` = `id_valid & id_ready`.
- `imem_req` = `rst_n` & !`redirect` & (FETCH | (WAIT & `imem_rvalid`)) & (`slots` − `pop` < 2). DISCARD never requests.
- On `imem_req & imem_gnt`: capture PC as in-flight tag, PC += 4 (wraps modulo 2^ADDR_W), next state WAIT.
- WAIT & `imem_rvalid` with no redirect: push {`imem_rdata`, tag}. Next state is WAIT if a new request was granted in the same cycle, else FETCH.
- Queue: 2 entries, FIFO order. Push and pop in the same cycle are both honoured. Push never occurs when full; the `slots` rule guarantees this.
- `redirect`, highest priority:
  - flush queue (count = 0), PC ← `redirect_pc`.
  - If WAIT without `imem_rvalid` this cycle, go to DISCARD. If WAIT with `imem_rvalid`, drop the data and go to FETCH.
  - In DISCARD, stay DISCARD (only the PC is updated).
  - A `pop` in the same cycle is still counted as consumed by decode.
- DISCARD & `imem_rvalid`: drop the word, go to FETCH.

## Timing
- Reset values: state FETCH, PC = `RESET_PC`, queue empty.
  - Outputs: `imem_req` 0, `imem_addr` `RESET_PC`, `id_valid` 0, `id_instr`/`id_op`/`id_pc` 0, `id_illegal` 0.
  - Reset mid-operation abandons any pending response; a late `imem_rvalid` after reset is ignored.
- `imem_req` is asserted the first cycle after reset deasserts.
- Fetch latency: grant at cycle N, `imem_rvalid` at N+k (k ≥ 1), `id_valid` at N+k+1.
- `id_*` outputs are registered queue-head values and are stable while `id_valid & !id_ready`.
- Throughput with k = 1 and `id_ready` held high: one instruction per cycle after the first.
- Redirect at cycle R:
  - `id_valid` = 0 at R+1.
  - `imem_req` with `imem_addr` = `redirect_pc` at R+1 if not DISCARD; otherwise the cycle after the dropped response.
- `imem_req` may be held across cycles without grant; `imem_addr` stays constant until granted.

## Test plan
- Reset then 1-cycle memory returning 0x0000_0000, 0x0400_0000 … with `id_ready` = 1:
  - `imem_addr` 0, 4, 8 on consecutive cycles.
  - `id_valid` from cycle 3.
  - `id_op` 0, 1, … and `id_pc` 0, 4, ….
- Hold `id_ready` = 0:
  - after 2 responses, `imem_req` drops and `id_instr`/`id_pc` stay frozen.
  - Raise `id_ready`: both entries drain in order, then fetching resumes at PC 8.
- 3-cycle memory latency, `redirect` (`redirect_pc` = 0x100) one cycle after grant:
  - enters DISCARD; returned word never appears on `id_*`.
  - Next request `imem_addr` = 0x100 the cycle after `imem_rvalid`.
- `redirect` coincident with `imem_rvalid` and a pending pop:
  - data dropped, queue empty next cycle.
  - `imem_req` at `redirect_pc` on the next cycle.
- Response word with op = 7, then op = 21:
  - `id_illegal` = 1 for the first, 0 for the second.
- Assert `rst_n` = 0 for one cycle while in WAIT, then deliver a stale `imem_rvalid`:
  - all outputs at reset values, stale word ignored.
  - Fetch restarts at `RESET_PC`.
